fifo_drain_arbiter: RTL and testbench

Read-side controller that shares one downstream byte consumer between two 8-bit FIFO instances in the rclk domain. It round-robins between the FIFOs in bursts, drives each FIFO's read enable, captures the popped byte, and presents it on a valid/ready output tagged with channel and end-of-burst. It is the only reader of both FIFOs.

---
 rtl/fifo_drain_arbiter.sv | 149 ++++++++++++++
 tb/tb_fifo_drain_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_arbiter.sv
// Read-side arbiter draining two byte FIFOs in round-robin bursts onto one
// registered valid/ready stream tagged with channel and end-of-burst.
module fifo_drain_arbiter #(
  parameter int unsigned BURST_MAX = 16
) (
  input  logic       rclk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fifo0_empty,
  input  logic [7:0] fifo0_rdata,
  output logic       fifo0_read_en,
  input  logic       fifo1_empty,
  input  logic [7:0] fifo1_rdata,
  output logic       fifo1_read_en,
  output logic [7:0] out_data,
  output logic       out_chan,
  output logic       out_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    CAP  = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(BURST_MAX - 1);

  state_t     state_r, state_s;
  logic       rr_ptr_r, rr_ptr_s;
  logic       grant_r, grant_s;
  logic [7:0] burst_cnt_r, burst_cnt_s;
  logic       rd_en0_r, rd_en0_s;
  logic       rd_en1_r, rd_en1_s;
  logic [7:0] data_r, data_s;
  logic       chan_r, chan_s;
  logic       last_r, last_s;
  logic       valid_r, valid_s;
  logic       busy_r, busy_s;
  logic       grant_empty_s;
  logic [7:0] grant_rdata_s;

  // Next-state and next-output logic for the burst controller.
  always_comb begin
    state_s       = state_r;
    rr_ptr_s      = rr_ptr_r;
    grant_s       = grant_r;
    burst_cnt_s   = burst_cnt_r;
    rd_en0_s      = 1'b0;
    rd_en1_s      = 1'b0;
    data_s        = data_r;
    chan_s        = chan_r;
    last_s        = last_r;
    valid_s       = valid_r;
    grant_empty_s = grant_r ? fifo1_empty : fifo0_empty;
    grant_rdata_s = grant_r ? fifo1_rdata : fifo0_rdata;

    case (state_r)
      IDLE: begin
        if (enable && !(fifo0_empty && fifo1_empty)) begin
          // A lone non-empty channel wins regardless of the round-robin pointer.
          if (!fifo0_empty && !fifo1_empty) begin
            grant_s = rr_ptr_r;
          end else begin
            grant_s = fifo0_empty;
          end
          rd_en0_s    = ~grant_s;
          rd_en1_s    = grant_s;
          burst_cnt_s = 8'd0;
          state_s     = POP;
        end else begin
          state_s = IDLE;
        end
      end
      POP: begin
        state_s = CAP;
      end
      CAP: begin
        data_s  = grant_rdata_s;
        chan_s  = grant_r;
        valid_s = 1'b1;
        last_s  = grant_empty_s || (burst_cnt_r == LAST_CNT);
        state_s = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          burst_cnt_s = burst_cnt_r + 8'd1;
          valid_s     = 1'b0;
          if (!last_r) begin
            rd_en0_s = ~grant_r;
            rd_en1_s = grant_r;
            state_s  = POP;
          end else begin
            rr_ptr_s = ~grant_r;
            state_s  = IDLE;
          end
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  // State and registered-output update with asynchronous reset.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      rr_ptr_r    <= 1'b0;
      grant_r     <= 1'b0;
      burst_cnt_r <= 8'd0;
      rd_en0_r    <= 1'b0;
      rd_en1_r    <= 1'b0;
      data_r      <= 8'd0;
      chan_r      <= 1'b0;
      last_r      <= 1'b0;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      rr_ptr_r    <= rr_ptr_s;
      grant_r     <= grant_s;
      burst_cnt_r <= burst_cnt_s;
      rd_en0_r    <= rd_en0_s;
      rd_en1_r    <= rd_en1_s;
      data_r      <= data_s;
      chan_r      <= chan_s;
      last_r      <= last_s;
      valid_r     <= valid_s;
      busy_r      <= busy_s;
    end
  end

  assign fifo0_read_en = rd_en0_r;
  assign fifo1_read_en = rd_en1_r;
  assign out_data      = data_r;
  assign out_chan      = chan_r;
  assign out_last      = last_r;
  assign out_valid     = valid_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: two queue-backed FIFO models, directed vector
// tables, corner sequences and randomized drains against a burst-level model.
module tb_fifo_drain_arbiter;

  localparam int BM = 4;

  logic       rclk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       fifo0_empty = 1'b1;
  logic [7:0] fifo0_rdata = 8'd0;
  logic       fifo0_read_en;
  logic       fifo1_empty = 1'b1;
  logic [7:0] fifo1_rdata = 8'd0;
  logic       fifo1_read_en;
  logic [7:0] out_data;
  logic       out_chan;
  logic       out_last;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;

  fifo_drain_arbiter #(.BURST_MAX(BM)) dut (
    .rclk(rclk), .reset(reset), .enable(enable),
    .fifo0_empty(fifo0_empty), .fifo0_rdata(fifo0_rdata), .fifo0_read_en(fifo0_read_en),
    .fifo1_empty(fifo1_empty), .fifo1_rdata(fifo1_rdata), .fifo1_read_en(fifo1_read_en),
    .out_data(out_data), .out_chan(out_chan), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 rclk = ~rclk;

  typedef struct { logic [7:0] data; logic chan; logic last; } rec_t;
  typedef struct { int stall; logic [7:0] data; logic chan; logic last; } vec_t;

  int checks = 0;
  int failures = 0;
  logic [7:0] q0[$], q1[$], m0[$], m1[$];
  rec_t got[$], exp_q[$];
  bit s_re0 = 1'b0, s_re1 = 1'b0, s_valid = 1'b0, s_chan = 1'b0, s_last = 1'b0, s_busy = 1'b0;
  logic [7:0] s_data = 8'd0;
  int pulses0 = 0, pulses1 = 0, pop_err = 0, overlap_err = 0, long_err = 0;
  int cyc = 0, first_re = -1, first_val = -1;
  vec_t vecs[23];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit ch, input logic [7:0] d);
    if (ch) begin q1.push_back(d); fifo1_empty = 1'b0; end
    else begin q0.push_back(d); fifo0_empty = 1'b0; end
  endtask

  // One clock: handshake bookkeeping, FIFO pops at the edge, negedge sampling.
  task automatic tick();
    bit p0, p1;
    rec_t r;
    if (s_valid && out_ready) begin
      r.data = s_data; r.chan = s_chan; r.last = s_last;
      got.push_back(r);
    end
    p0 = s_re0;
    p1 = s_re1;
    @(posedge rclk);
    #1;
    if (p0) begin
      if (q0.size() == 0) pop_err++;
      else fifo0_rdata = q0.pop_front();
    end
    if (p1) begin
      if (q1.size() == 0) pop_err++;
      else fifo1_rdata = q1.pop_front();
    end
    fifo0_empty = (q0.size() == 0);
    fifo1_empty = (q1.size() == 0);
    @(negedge rclk);
    if ((fifo0_read_en && s_re0) || (fifo1_read_en && s_re1)) long_err++;
    s_re0 = fifo0_read_en; s_re1 = fifo1_read_en;
    s_valid = out_valid; s_data = out_data; s_chan = out_chan; s_last = out_last; s_busy = busy;
    if (s_re0 && s_re1) overlap_err++;
    if (s_re0) pulses0++;
    if (s_re1) pulses1++;
    cyc++;
    if ((s_re0 || s_re1) && first_re < 0) first_re = cyc;
    if (s_valid && first_val < 0) first_val = cyc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    s_re0 = 1'b0; s_re1 = 1'b0; s_valid = 1'b0; s_busy = 1'b0;
    q0.delete(); q1.delete();
    fifo0_empty = 1'b1; fifo1_empty = 1'b1;
    out_ready = 1'b0; enable = 1'b0;
    tick(); tick();
    reset = 1'b0;
    got.delete();
    pulses0 = 0; pulses1 = 0; first_re = -1; first_val = -1;
  endtask

  task automatic run_vectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      int n, bad;
      logic [7:0] hd;
      bit hc, hl;
      n = 0; bad = 0;
      out_ready = 1'b0;
      while (!s_valid && n < 20) begin tick(); n++; end
      chk("vec_wait_valid", int'(s_valid), 1);
      hd = s_data; hc = s_chan; hl = s_last;
      for (int k = 0; k < vecs[i].stall; k++) begin
        tick();
        if (s_data != hd || s_chan != hc || s_last != hl || !s_valid || s_re0 || s_re1) bad++;
      end
      if (vecs[i].stall > 0) chk("hold_stable", bad, 0);
      chk("vec_data", int'(s_data), int'(vecs[i].data));
      chk("vec_chan", int'(s_chan), int'(vecs[i].chan));
      chk("vec_last", int'(s_last), int'(vecs[i].last));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      if (!vecs[i].last) chk("next_pop", int'(vecs[i].chan ? s_re1 : s_re0), 1);
    end
  endtask

  task automatic drain(input bit rnd);
    int n;
    n = 0;
    do begin
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      tick();
      n++;
    end while (!(n >= 4 && !s_busy && !s_valid && q0.size() == 0 && q1.size() == 0) && n < 800);
    chk("drain_done", int'(n < 800), 1);
    out_ready = 1'b0;
  endtask

  // Burst-level reference: whole bursts of up to BM bytes, alternating preference.
  function automatic void build_expect();
    int rr, g, taken, left;
    rec_t r;
    rr = 0;
    exp_q.delete();
    while (m0.size() > 0 || m1.size() > 0) begin
      if (m0.size() > 0 && m1.size() > 0) g = rr;
      else g = (m0.size() > 0) ? 0 : 1;
      taken = 0;
      left = (g == 0) ? m0.size() : m1.size();
      while (taken < BM && left > 0) begin
        r.data = (g == 0) ? m0.pop_front() : m1.pop_front();
        taken++;
        left = (g == 0) ? m0.size() : m1.size();
        r.chan = (g == 1);
        r.last = (taken == BM) || (left == 0);
        exp_q.push_back(r);
      end
      rr = 1 - g;
    end
  endfunction

  initial begin
    int n, n0, n1, busy_seen;

    vecs = '{
      '{0, 8'hA1, 1'b0, 1'b0}, '{0, 8'hA2, 1'b0, 1'b0}, '{0, 8'hA3, 1'b0, 1'b1},
      '{0, 8'h00, 1'b0, 1'b0}, '{10, 8'h01, 1'b0, 1'b0}, '{0, 8'h02, 1'b0, 1'b0}, '{2, 8'h03, 1'b0, 1'b1},
      '{0, 8'h10, 1'b1, 1'b0}, '{0, 8'h11, 1'b1, 1'b0}, '{3, 8'h12, 1'b1, 1'b0}, '{0, 8'h13, 1'b1, 1'b1},
      '{0, 8'h04, 1'b0, 1'b0}, '{0, 8'h05, 1'b0, 1'b0}, '{0, 8'h06, 1'b0, 1'b0}, '{0, 8'h07, 1'b0, 1'b1},
      '{0, 8'h14, 1'b1, 1'b0}, '{1, 8'h15, 1'b1, 1'b0}, '{0, 8'h16, 1'b1, 1'b0}, '{0, 8'h17, 1'b1, 1'b1},
      '{0, 8'h08, 1'b0, 1'b0}, '{0, 8'h09, 1'b0, 1'b1},
      '{0, 8'h18, 1'b1, 1'b0}, '{0, 8'h19, 1'b1, 1'b1}
    };

    // Reset with random inputs: every output held at zero.
    for (int i = 0; i < 3; i++) begin
      @(negedge rclk);
      enable = 1'($urandom()); out_ready = 1'($urandom());
      fifo0_empty = 1'($urandom()); fifo1_empty = 1'($urandom());
      fifo0_rdata = 8'($urandom()); fifo1_rdata = 8'($urandom());
      #1;
      chk("reset_outs", int'({fifo0_read_en, fifo1_read_en, out_data, out_chan, out_last, out_valid, busy}), 0);
    end
    @(negedge rclk);
    fifo0_empty = 1'b1; fifo1_empty = 1'b1; enable = 1'b0; out_ready = 1'b0;
    reset = 1'b0;
    tick();
    chk("post_reset_outs", int'({fifo0_read_en, fifo1_read_en, out_data, out_chan, out_last, out_valid, busy}), 0);

    // Single channel, short burst ended by empty.
    do_reset();
    enable = 1'b1;
    push(0, 8'hA1); push(0, 8'hA2); push(0, 8'hA3);
    run_vectors(0, 2);
    for (int i = 0; i < 5; i++) tick();
    chk("t2_pulses0", pulses0, 3);
    chk("t2_pulses1", pulses1, 0);
    chk("t2_latency", first_val - first_re, 2);
    chk("t2_idle", int'(s_busy), 0);

    // Two channels, bursts of BM with a long stall.
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(0, 8'(i)); push(1, 8'(8'h10 + i));
    end
    run_vectors(3, 22);
    for (int i = 0; i < 5; i++) tick();
    chk("t3_pulses0", pulses0, 10);
    chk("t3_pulses1", pulses1, 10);

    // Enable low blocks new bursts; dropping it mid-burst does not cut it short.
    do_reset();
    for (int i = 0; i < 6; i++) push(0, 8'(8'h50 + i));
    push(1, 8'h60); push(1, 8'h61);
    busy_seen = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin tick(); if (s_busy) busy_seen++; end
    chk("t5_no_pulse", pulses0 + pulses1, 0);
    chk("t5_no_busy", busy_seen, 0);
    enable = 1'b1;
    n = 0;
    while (!s_valid && n < 20) begin tick(); n++; end
    enable = 1'b0;
    n = 0;
    while (s_busy && n < 40) begin tick(); n++; end
    for (int i = 0; i < 10; i++) tick();
    chk("t5_count", got.size(), 4);
    if (got.size() == 4) begin
      chk("t5_first", int'(got[0].data), 8'h50);
      chk("t5_fourth", int'(got[3].data), 8'h53);
      chk("t5_last4", int'(got[3].last), 1);
      chk("t5_last3", int'(got[2].last), 0);
    end
    chk("t5_pulses", pulses0 + pulses1, 4);
    chk("t5_idle", int'(s_busy), 0);
    out_ready = 1'b0;

    // Reset while holding a channel 1 byte: output drops, arbitration restarts at 0.
    do_reset();
    enable = 1'b1; out_ready = 1'b1;
    push(0, 8'h20); push(1, 8'h30); push(1, 8'h31);
    n = 0;
    while (!(s_valid && s_chan) && n < 40) begin tick(); n++; end
    out_ready = 1'b0;
    chk("t6_hold_ch1", int'(s_valid && s_chan), 1);
    push(0, 8'h40);
    reset = 1'b1;
    #1;
    chk("t6_valid_drop", int'(out_valid), 0);
    s_re0 = 1'b0; s_re1 = 1'b0; s_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    got.delete();
    n = 0;
    while (!(s_re0 || s_re1) && n < 10) begin tick(); n++; end
    chk("t6_grant_ch0", int'(s_re0), 1);
    chk("t6_not_ch1", int'(s_re1), 0);
    drain(1'b0);
    chk("t6_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("t6_byte0", int'(got[0].data), 8'h40);
      chk("t6_byte1", int'(got[1].data), 8'h31);
    end

    // Randomized contents and backpressure against the burst-level model.
    for (int it = 0; it < 8; it++) begin
      do_reset();
      n0 = $urandom_range(0, 11);
      n1 = $urandom_range(0, 11);
      for (int i = 0; i < n0; i++) push(0, 8'($urandom()));
      for (int i = 0; i < n1; i++) push(1, 8'($urandom()));
      m0 = q0; m1 = q1;
      build_expect();
      enable = 1'b1;
      drain(1'b1);
      chk("rnd_len", got.size(), exp_q.size());
      for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
        chk("rnd_data", int'(got[k].data), int'(exp_q[k].data));
        chk("rnd_chan", int'(got[k].chan), int'(exp_q[k].chan));
        chk("rnd_last", int'(got[k].last), int'(exp_q[k].last));
      end
      chk("rnd_pops0", pulses0, n0);
      chk("rnd_pops1", pulses1, n1);
    end

    chk("pop_on_empty", pop_err, 0);
    chk("read_en_overlap", overlap_err, 0);
    chk("read_en_width", long_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
